// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up on the DONE-entry edge.
module ex_muldiv_unit #(
    parameter bit          MUL_FAST = 1'b0,
    parameter int unsigned ITER     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdStartEX,
    input  logic [2:0]  mdOpEX,
    input  logic [31:0] operandAEX,
    input  logic [31:0] operandBEX,
    input  logic        flushEX,
    output logic        mdStallEX,
    output logic        mdResultValidEX,
    output logic [31:0] mdResultEX
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (ITER != 32) begin : g_bad_iter
            $error("ex_muldiv_unit: only ITER=32 is supported");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      divisor_q, divisor_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic [31:0]      result_q, result_d;
    logic             valid_q, valid_d;

    // Operand signedness and magnitudes for the incoming instruction
    logic        sign_a_en, sign_b_en, sa, sb;
    logic [31:0] mag_a, mag_b;
    logic [63:0] fast_prod;
    logic        div_zero, div_ovf, take_fast;
    logic [31:0] fast_res;

    // Apply result signs: 64-bit negate for products, separate quotient/remainder signs for divides
    function automatic logic [31:0] md_finalize(input logic [2:0] op, input logic neg,
                                                input logic neg_rem, input logic [31:0] hi,
                                                input logic [31:0] lo);
        logic [63:0] p;
        logic [31:0] r;
        p = {hi, lo};
        if (neg) p = ~p + 64'd1;
        case (op)
            3'd0:          r = p[31:0];
            3'd4, 3'd5:    r = neg ? (~lo + 32'd1) : lo;
            3'd6, 3'd7:    r = neg_rem ? (~hi + 32'd1) : hi;
            default:       r = p[63:32];
        endcase
        return r;
    endfunction

    assign sign_a_en = mdOpEX[2] ? ~mdOpEX[0] : (mdOpEX[1:0] != 2'b11);
    assign sign_b_en = mdOpEX[2] ? ~mdOpEX[0] : ~mdOpEX[1];
    assign sa        = sign_a_en & operandAEX[31];
    assign sb        = sign_b_en & operandBEX[31];
    assign mag_a     = sa ? (~operandAEX + 32'd1) : operandAEX;
    assign mag_b     = sb ? (~operandBEX + 32'd1) : operandBEX;
    assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};

    assign div_zero  = mdOpEX[2] & (operandBEX == 32'd0);
    assign div_ovf   = mdOpEX[2] & ~mdOpEX[0] & (operandAEX == 32'h8000_0000)
                     & (operandBEX == 32'hFFFF_FFFF);
    assign take_fast = div_zero | div_ovf | (MUL_FAST & ~mdOpEX[2]);

    always_comb begin
        fast_res = md_finalize(mdOpEX, sa ^ sb, sa, fast_prod[63:32], fast_prod[31:0]);
        if (div_zero) begin
            fast_res = mdOpEX[1] ? operandAEX : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fast_res = mdOpEX[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration: shift-add on {hi,lo} for multiply, restoring step for divide
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_sub;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, divisor_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_sub   = div_shift[31:0] - divisor_q;
        if (op_q[2]) begin
            if (div_shift >= {1'b0, divisor_q}) begin
                step_hi = div_sub;
                step_lo = {lo_q[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {lo_q[30:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo_q[31:1]};
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divisor_d = divisor_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdStartEX) begin
                    op_d      = mdOpEX;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    hi_d      = 32'd0;
                    lo_d      = mag_a;
                    divisor_d = mag_b;
                    count_d   = '0;
                    if (take_fast) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = CNT_W'(count_q + 5'd1);
                if (count_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = md_finalize(op_q, neg_q, neg_rem_q, step_hi, step_lo);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (flushEX) begin
            state_d  = S_IDLE;
            count_d  = '0;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= 3'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            divisor_q <= 32'd0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divisor_q <= divisor_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign mdStallEX       = ((state_q == S_IDLE) & mdStartEX & ~flushEX) | (state_q == S_CALC);
    assign mdResultValidEX = valid_q;
    assign mdResultEX      = result_q;

endmodule
